// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 sizes, exception causes and LSU state encoding
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - store lane replication/strobes and load lane extraction/extension
module riscv_lsu_align #(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] offset_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [NB-1:0]   wstrb_o,
  output logic [XLEN-1:0] load_data_o
);

  int              bits;
  int              msb;
  logic            sign;
  logic [XLEN-1:0] shifted;

  always_comb begin
    bits    = 8 << funct3_i[1:0];
    // D on a 32-bit hart is rejected upstream; clamp so indices stay in range
    msb     = (bits > XLEN) ? XLEN - 1 : bits - 1;
    wdata_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      wdata_o[i] = store_data_i[i % bits];
    end
    wstrb_o     = NB'((1 << (bits / 8)) - 1) << offset_i;
    shifted     = rdata_i >> {offset_i, 3'b000};
    sign        = ~funct3_i[2] & shifted[msb];
    load_data_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      load_data_o[i] = (i <= msb) ? shifted[i] : sign;
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - memory-access stage: accepts EX ops, runs bus loads/stores, pulses WB results
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGN = 32,
  parameter int REGA = $clog2(REGN),
  parameter int NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [REGA-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_load,
  input  logic            ex_store,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [REGA-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exception,
  output logic [3:0]      wb_cause
);

  localparam int OFFW = $clog2(NB);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            store_q, store_d;
  logic [REGA-1:0] rd_q, rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [REGA-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_exc_q, wb_exc_d;
  logic [3:0]      wb_cause_q, wb_cause_d;

  logic [XLEN-1:0] align_wdata;
  logic [NB-1:0]   align_wstrb;
  logic [XLEN-1:0] align_ldata;
  logic            mem_op;
  logic            illegal;
  logic            misalign;
  logic [2:0]      amask;

  riscv_lsu_align #(.XLEN(XLEN), .NB(NB), .OFFW(OFFW)) u_align (
    .offset_i     (addr_q[OFFW-1:0]),
    .funct3_i     (funct3_q),
    .store_data_i (sdata_q),
    .rdata_i      (mem_rdata),
    .wdata_o      (align_wdata),
    .wstrb_o      (align_wstrb),
    .load_data_o  (align_ldata)
  );

  assign ex_ready     = (state_q == ST_IDLE) & ~rst;
  assign mem_req      = (state_q == ST_REQ);
  assign mem_we       = mem_req & store_q;
  assign mem_addr     = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign mem_wdata    = align_wdata;
  assign mem_wstrb    = mem_we ? align_wstrb : '0;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;
  assign wb_cause     = wb_cause_q;

  // Accept-time checks; funct3 only matters when the op touches memory
  always_comb begin
    mem_op   = ex_load | ex_store;
    amask    = 3'((1 << ex_funct3[1:0]) - 1);
    misalign = |(ex_result[2:0] & amask);
    illegal  = (ex_load & ex_store) |
               (mem_op & ((ex_funct3 == 3'd7) |
                          ((XLEN == 32) & ((ex_funct3 == F3_D) | (ex_funct3 == F3_WU))) |
                          (ex_store & ex_funct3[2])));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_exc_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_cause_d = wb_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (illegal | (mem_op & misalign)) begin
            wb_valid_d = 1'b1;
            wb_exc_d   = 1'b1;
            wb_rd_d    = '0;
            wb_data_d  = ex_result;
            wb_cause_d = illegal ? CAUSE_ILLEGAL :
                         (ex_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN);
          end else if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
          end else begin
            addr_d   = ex_result;
            sdata_d  = ex_store_data;
            funct3_d = ex_funct3;
            store_d  = ex_store;
            rd_d     = ex_rd;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (store_q) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = '0;
            wb_data_d  = '0;
          end else begin
            state_d = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = align_ldata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
      wb_cause_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      funct3_q   <= funct3_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
      wb_cause_q <= wb_cause_d;
    end
  end

endmodule
